spi_master_shifter: RTL

SPI master shift engine for the rangefinder sensor link, directly downstream of the SPI clock divider. It consumes the divider's single-cycle `slow_clk_en` tick as its half-bit time base and drives chip-select, SCLK and MOSI. It shifts one MSB-first word out while capturing one word from MISO, using SPI mode 0 (CPOL=0, CPHA=0). It then returns the captured word with a one-cycle `done` pulse.

---
 rtl/spi_master_shifter.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/spi_master_shifter.sv
// -----------------------------------------------------------------------------
// spi_master_shifter
//
// SPI mode-0 (CPOL=0, CPHA=0) master shift engine. The half-bit time base is
// the single-cycle slow_clk_en tick from the upstream SPI clock divider. One
// word is shifted out MSB-first on mosi while one word is captured from miso.
// The captured word is presented on rx_data together with a one-cycle done
// pulse.
//
// Ports
//   clk          in   system clock, rising edge
//   reset        in   asynchronous reset, active low
//   slow_clk_en  in   half-bit tick (one clk wide)
//   start        in   transfer request, honoured only while idle
//   tx_data      in   word to transmit, latched when start is accepted
//   miso         in   serial data from the slave (already clk-synchronous)
//   sclk         out  SPI clock, idles low
//   mosi         out  serial data to the slave
//   cs_n         out  slave select, active low
//   busy         out  high from start acceptance until done
//   done         out  one-cycle end-of-transfer pulse
//   rx_data      out  last captured word, held until the next done
// -----------------------------------------------------------------------------
module spi_master_shifter #(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              slow_clk_en,
    input  logic              start,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              miso,
    output logic              sclk,
    output logic              mosi,
    output logic              cs_n,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] rx_data
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_XFER  = 2'd2,
        ST_HOLD  = 2'd3
    } state_t;

    // Index of the final SCLK edge (a falling edge) within XFER, counted from 0.
    localparam logic [5:0] LAST_EDGE = 6'(2 * DATA_W - 1);

    state_t            state_q;
    logic [DATA_W-1:0] tx_sr_q;
    logic [DATA_W-1:0] rx_sr_q;
    logic [5:0]        edge_cnt_q;
    logic              sclk_q;
    logic              mosi_q;
    logic              cs_n_q;
    logic              busy_q;
    logic              done_q;
    logic [DATA_W-1:0] rx_data_q;

    logic [DATA_W-1:0] tx_sr_d;
    logic [DATA_W-1:0] rx_sr_d;
    logic [5:0]        edge_cnt_d;
    logic              last_edge_s;

    // Next values of the shift registers and edge counter for a shifting tick.
    always_comb begin
        tx_sr_d     = {tx_sr_q[DATA_W-2:0], 1'b0};
        rx_sr_d     = {rx_sr_q[DATA_W-2:0], miso};
        edge_cnt_d  = edge_cnt_q + 6'd1;
        last_edge_s = (edge_cnt_q == LAST_EDGE);
    end

    // Transfer FSM with all outputs registered.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            tx_sr_q    <= '0;
            rx_sr_q    <= '0;
            edge_cnt_q <= 6'd0;
            sclk_q     <= 1'b0;
            mosi_q     <= 1'b0;
            cs_n_q     <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            rx_data_q  <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    sclk_q <= 1'b0;
                    // A tick coinciding with acceptance is deliberately not
                    // consumed: SETUP waits for the next one.
                    if (start) begin
                        tx_sr_q    <= tx_data;
                        rx_sr_q    <= '0;
                        edge_cnt_q <= 6'd0;
                        mosi_q     <= tx_data[DATA_W-1];
                        cs_n_q     <= 1'b0;
                        busy_q     <= 1'b1;
                        state_q    <= ST_SETUP;
                    end else begin
                        cs_n_q <= 1'b1;
                        busy_q <= 1'b0;
                    end
                end
                ST_SETUP: begin
                    // One half-bit of cs_n-to-SCLK setup.
                    if (slow_clk_en) begin
                        state_q <= ST_XFER;
                    end else begin
                        state_q <= ST_SETUP;
                    end
                end
                ST_XFER: begin
                    if (slow_clk_en) begin
                        sclk_q     <= ~sclk_q;
                        edge_cnt_q <= edge_cnt_d;
                        if (!sclk_q) begin
                            // Rising edge: capture miso.
                            rx_sr_q <= rx_sr_d;
                        end else begin
                            // Falling edge: present the next bit.
                            tx_sr_q <= tx_sr_d;
                            mosi_q  <= tx_sr_q[DATA_W-2];
                        end
                        if (last_edge_s) begin
                            state_q <= ST_HOLD;
                        end else begin
                            state_q <= ST_XFER;
                        end
                    end else begin
                        state_q <= ST_XFER;
                    end
                end
                ST_HOLD: begin
                    if (slow_clk_en) begin
                        cs_n_q    <= 1'b1;
                        rx_data_q <= rx_sr_q;
                        done_q    <= 1'b1;
                        busy_q    <= 1'b0;
                        state_q   <= ST_IDLE;
                    end else begin
                        state_q <= ST_HOLD;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    sclk_q  <= 1'b0;
                    cs_n_q  <= 1'b1;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign sclk    = sclk_q;
    assign mosi    = mosi_q;
    assign cs_n    = cs_n_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign rx_data = rx_data_q;

endmodule
